tridiag_mxv_stream: RTL
=======================

# tridiag_mxv_stream

Parametrised streaming tridiagonal matrix-by-vector engine for the cluster Jacobi datapath. It computes y = A·x for one cluster's tridiagonal system and emits N_UNITS row results per beat over a valid/ready stream. It replaces fixed-width, free-running unit control with lane masking for partial last beats, output backpressure and a single finish pulse. It sits between the cluster matrix/vector store and the Jacobi update stage.

## Interface
- N_EQN, 10: equations (rows) per cluster, ≥2
- ELEM_W, 32: element width, signed two's-complement fixed point
- FRAC_BITS, 16: fractional bits of every element
- N_UNITS, 4: row lanes per beat, 1..N_EQN
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- mat  in  ELEM_W*(3*N_EQN-2)  packed tridiagonal, element k at [ELEM_W*k +: ELEM_W]; row r: sub at 3r-1, diag at 3r, super at 3r+1
- vector  in  ELEM_W*N_EQN  x, element i at [ELEM_W*i +: ELEM_W]
- out_data  out  ELEM_W*N_UNITS  lane j = y[out_base+j]
- out_mask  out  N_UNITS  lane valid bits
- out_base  out  clog2(N_EQN)+1  row index of lane 0
- out_last  out  1  final beat of the run
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- busy  out  1  run in progress
- finish  out  1  one-cycle done pulse
- ovf  out  1  sticky saturation flag (see Configuration)

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all outputs 0.
- IDLE: start=1 → latch mat and vector into internal registers, beat counter = 0, busy=1, go RUN. Inputs may change afterward.
- RUN: issues beat b = 0..NUM_BEATS-1, NUM_BEATS = ceil(N_EQN/N_UNITS); lane j computes row r = b*N_UNITS+j.
- y[r] = sub·x[r-1] + diag·x[r] + super·x[r+1]; out-of-range terms (r=0 sub, r=N_EQN-1 super) are zero.
- Lanes with r ≥ N_EQN: out_mask bit 0, data 0.
- Arithmetic: products signed 2*ELEM_W; sum sign-extended to 2*ELEM_W+2; arithmetic right shift by FRAC_BITS (floor); reduce to ELEM_W per Configuration.
- Transfer when out_valid && out_ready. Last beat transfer → DONE.
- DONE: finish=1 and busy=0 for one cycle → IDLE.
- start outside IDLE is ignored (no restart, no queueing).
- Reset mid-run: immediate abort, pipeline and outputs cleared, no finish.

## Timing
- Two-stage pipeline: stage 1 registers the 3·N_UNITS products, stage 2 registers sum/shift/reduce.
- start sampled at edge T → first out_valid after edge T+2.
- out_ready held high → one beat per cycle, no bubbles; finish asserted after the edge following the last transfer.
- Backpressure: out_valid && !out_ready freezes the whole pipeline; out_data, out_mask, out_base, out_last hold stable; nothing dropped or duplicated.
- out_valid never deasserts without a transfer.
- busy is 1 from edge T through the last transfer; it is 0 in the finish cycle.

## Configuration
- TRIDIAG_MXV_SAT_EN defined: results outside the signed ELEM_W range clamp to 2^(ELEM_W-1)-1 / -2^(ELEM_W-1); ovf set on any clamp of a masked-in lane, cleared only by reset or accepted start.
- Undefined: low ELEM_W bits kept (wrap); ovf tied 0; no saturation logic.

## Structure
- Shared package tridiag_mxv_pkg: clog2 function, NUM_BEATS and MAT_ELEMS (3*N_EQN-2) constant functions, state encoding constants.
- Sub-module tridiag_row_mac: one lane; three multipliers, adder, shift, reduce, with stage enable; instantiated N_UNITS times by generate.
- Top holds FSM, operand latches, beat counter, lane operand muxing, mask/base/last generation.

## Test plan
- N_EQN=10, N_UNITS=4, diag 2.0 (0x00020000), off-diagonals -1.0, x all 1.0, out_ready=1 → beats [1.0,0,0,0] mask 1111 base 0; [0,0,0,0] base 4; [0,1.0,0,0] mask 0011 base 8 last=1; finish one cycle later; first out_valid 2 cycles after start.
- Same stimulus, out_ready low 5 cycles during beat 1 → out_data/out_base hold 4; total 3 transfers, no duplicates.
- With TRIDIAG_MXV_SAT_EN: diag[0]=0x7FFF0000, x[0]=2.0, others 0 → y[0]=0x7FFFFFFF, ovf=1; undefined → y[0]=0xFFFE0000, ovf=0.
- N_EQN=8, N_UNITS=4, random values → 2 beats, both mask 1111; matches reference model bit-exactly.
- start pulsed during RUN → ignored; run completes normally with a single finish pulse.
- reset asserted during beat 1 → outputs 0 asynchronously, no finish; new start after release yields a correct full run.

Source files
------------

// File: rtl/tridiag_mxv_stream_pkg.sv
// Shared state encoding and constant helpers for the tridiagonal matrix-vector stream engine.
package tridiag_mxv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned num_beats(input int unsigned n_eqn, input int unsigned n_units);
        return (n_eqn + n_units - 1) / n_units;
    endfunction

    function automatic int unsigned mat_elems(input int unsigned n_eqn);
        return 3 * n_eqn - 2;
    endfunction

endpackage

// File: rtl/tridiag_mxv_stream_row_mac.sv
// One row lane: three products (stage 1), then sum, floor shift and reduce (stage 2).
// TRIDIAG_MXV_SAT_EN selects clamping reduction and exposes the clamp indication.
module tridiag_row_mac #(
    parameter int unsigned ELEM_W    = 32,
    parameter int unsigned FRAC_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic signed [ELEM_W-1:0] sub_i,
    input  logic signed [ELEM_W-1:0] diag_i,
    input  logic signed [ELEM_W-1:0] sup_i,
    input  logic signed [ELEM_W-1:0] xm_i,
    input  logic signed [ELEM_W-1:0] x0_i,
    input  logic signed [ELEM_W-1:0] xp_i,
    output logic        [ELEM_W-1:0] y_o
`ifdef TRIDIAG_MXV_SAT_EN
    ,
    output logic                     clamp_o
`endif
);

    localparam int unsigned PW = 2 * ELEM_W;
    localparam int unsigned SW = 2 * ELEM_W + 2;

    logic signed [PW-1:0] p_sub_q, p_sub_d;
    logic signed [PW-1:0] p_diag_q, p_diag_d;
    logic signed [PW-1:0] p_sup_q, p_sup_d;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shifted;
    logic [ELEM_W-1:0]    y_q, y_d;

`ifdef TRIDIAG_MXV_SAT_EN
    localparam logic signed [SW-1:0] MAX_V = SW'({1'b0, {(ELEM_W-1){1'b1}}});
    localparam logic signed [SW-1:0] MIN_V = -MAX_V - SW'(1);
`endif

    always_comb begin
        p_sub_d  = PW'(sub_i)  * PW'(xm_i);
        p_diag_d = PW'(diag_i) * PW'(x0_i);
        p_sup_d  = PW'(sup_i)  * PW'(xp_i);
        sum      = SW'(p_sub_q) + SW'(p_diag_q) + SW'(p_sup_q);
        shifted  = sum >>> FRAC_BITS;
`ifdef TRIDIAG_MXV_SAT_EN
        clamp_o = 1'b0;
        y_d     = ELEM_W'(shifted);
        if (shifted > MAX_V) begin
            y_d     = MAX_V[ELEM_W-1:0];
            clamp_o = 1'b1;
        end else if (shifted < MIN_V) begin
            y_d     = MIN_V[ELEM_W-1:0];
            clamp_o = 1'b1;
        end
`else
        y_d = ELEM_W'(shifted);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_sub_q  <= '0;
            p_diag_q <= '0;
            p_sup_q  <= '0;
            y_q      <= '0;
        end else if (en) begin
            p_sub_q  <= p_sub_d;
            p_diag_q <= p_diag_d;
            p_sup_q  <= p_sup_d;
            y_q      <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/tridiag_mxv_stream.sv
// Streaming tridiagonal y = A*x engine: N_UNITS rows per beat, valid/ready output, finish pulse.
// TRIDIAG_MXV_SAT_EN enables saturating reduction and the sticky ovf flag.
module tridiag_mxv_stream
    import tridiag_mxv_pkg::*;
#(
    parameter int unsigned N_EQN     = 10,
    parameter int unsigned ELEM_W    = 32,
    parameter int unsigned FRAC_BITS = 16,
    parameter int unsigned N_UNITS   = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [ELEM_W*mat_elems(N_EQN)-1:0]    mat,
    input  logic [ELEM_W*N_EQN-1:0]               vector,
    output logic [ELEM_W*N_UNITS-1:0]             out_data,
    output logic [N_UNITS-1:0]                    out_mask,
    output logic [clog2(N_EQN):0]                 out_base,
    output logic                                  out_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  busy,
    output logic                                  finish,
    output logic                                  ovf
);

    localparam int unsigned NB     = num_beats(N_EQN, N_UNITS);
    localparam int unsigned BASE_W = clog2(N_EQN) + 1;
    localparam int unsigned BEAT_W = clog2(NB + 1);
    localparam int unsigned MAT_W  = ELEM_W * mat_elems(N_EQN);
    localparam int unsigned VEC_W  = ELEM_W * N_EQN;

    state_e              state_q, state_d;
    logic [MAT_W-1:0]    mat_q, mat_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                s1_valid_q, s1_valid_d;
    logic [N_UNITS-1:0]  s1_mask_q, s1_mask_d;
    logic [BASE_W-1:0]   s1_base_q, s1_base_d;
    logic                s1_last_q, s1_last_d;
    logic                out_valid_q, out_valid_d;
    logic [N_UNITS-1:0]  out_mask_q, out_mask_d;
    logic [BASE_W-1:0]   out_base_q, out_base_d;
    logic                out_last_q, out_last_d;

    logic                adv;
    logic                issue;
    logic [N_UNITS-1:0]  lane_mask;
    logic signed [ELEM_W-1:0] l_sub [N_UNITS];
    logic signed [ELEM_W-1:0] l_diag[N_UNITS];
    logic signed [ELEM_W-1:0] l_sup [N_UNITS];
    logic signed [ELEM_W-1:0] l_xm  [N_UNITS];
    logic signed [ELEM_W-1:0] l_x0  [N_UNITS];
    logic signed [ELEM_W-1:0] l_xp  [N_UNITS];

    // A stalled output beat freezes both pipeline stages and the issue counter together.
    assign adv   = !(out_valid_q && !out_ready);
    assign issue = (state_q == ST_RUN) && (beat_q < BEAT_W'(NB)) && adv;

    // Lanes past the last row (or idle cycles) get zero operands, so they produce 0 and never clamp.
    always_comb begin
        int unsigned r;
        lane_mask = '0;
        for (int unsigned j = 0; j < N_UNITS; j++) begin
            l_sub[j]  = '0;
            l_diag[j] = '0;
            l_sup[j]  = '0;
            l_xm[j]   = '0;
            l_x0[j]   = '0;
            l_xp[j]   = '0;
            r = 32'(beat_q) * N_UNITS + j;
            if (issue && r < N_EQN) begin
                lane_mask[j] = 1'b1;
                l_diag[j] = mat_q[ELEM_W*(3*r) +: ELEM_W];
                l_x0[j]   = vec_q[ELEM_W*r +: ELEM_W];
                if (r > 0) begin
                    l_sub[j] = mat_q[ELEM_W*(3*r-1) +: ELEM_W];
                    l_xm[j]  = vec_q[ELEM_W*(r-1) +: ELEM_W];
                end
                if (r < N_EQN - 1) begin
                    l_sup[j] = mat_q[ELEM_W*(3*r+1) +: ELEM_W];
                    l_xp[j]  = vec_q[ELEM_W*(r+1) +: ELEM_W];
                end
            end
        end
    end

`ifdef TRIDIAG_MXV_SAT_EN
    logic [N_UNITS-1:0] lane_clamp;
    logic               ovf_q, ovf_d;
`endif

    always_comb begin
        state_d     = state_q;
        mat_d       = mat_q;
        vec_d       = vec_q;
        beat_d      = beat_q;
        s1_valid_d  = s1_valid_q;
        s1_mask_d   = s1_mask_q;
        s1_base_d   = s1_base_q;
        s1_last_d   = s1_last_q;
        out_valid_d = out_valid_q;
        out_mask_d  = out_mask_q;
        out_base_d  = out_base_q;
        out_last_d  = out_last_q;
`ifdef TRIDIAG_MXV_SAT_EN
        ovf_d       = ovf_q;
`endif
        unique case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_RUN;
                mat_d   = mat;
                vec_d   = vector;
                beat_d  = '0;
`ifdef TRIDIAG_MXV_SAT_EN
                ovf_d   = 1'b0;
`endif
            end
            ST_RUN: begin
                if (issue) beat_d = beat_q + BEAT_W'(1);
                if (out_valid_q && out_ready && out_last_q) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (adv) begin
            s1_valid_d  = issue;
            s1_mask_d   = lane_mask;
            s1_base_d   = issue ? BASE_W'(32'(beat_q) * N_UNITS) : '0;
            s1_last_d   = issue && (beat_q == BEAT_W'(NB - 1));
            out_valid_d = s1_valid_q;
            out_mask_d  = s1_mask_q;
            out_base_d  = s1_base_q;
            out_last_d  = s1_last_q;
`ifdef TRIDIAG_MXV_SAT_EN
            if (|lane_clamp) ovf_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mat_q       <= '0;
            vec_q       <= '0;
            beat_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_mask_q   <= '0;
            s1_base_q   <= '0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_mask_q  <= '0;
            out_base_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mat_q       <= mat_d;
            vec_q       <= vec_d;
            beat_q      <= beat_d;
            s1_valid_q  <= s1_valid_d;
            s1_mask_q   <= s1_mask_d;
            s1_base_q   <= s1_base_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_mask_q  <= out_mask_d;
            out_base_q  <= out_base_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef TRIDIAG_MXV_SAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    for (genvar g = 0; g < N_UNITS; g++) begin : g_lane
        tridiag_row_mac #(
            .ELEM_W   (ELEM_W),
            .FRAC_BITS(FRAC_BITS)
        ) u_mac (
            .clk    (clk),
            .reset  (reset),
            .en     (adv),
            .sub_i  (l_sub[g]),
            .diag_i (l_diag[g]),
            .sup_i  (l_sup[g]),
            .xm_i   (l_xm[g]),
            .x0_i   (l_x0[g]),
            .xp_i   (l_xp[g]),
            .y_o    (out_data[ELEM_W*g +: ELEM_W])
`ifdef TRIDIAG_MXV_SAT_EN
            ,
            .clamp_o(lane_clamp[g])
`endif
        );
    end

    assign out_mask  = out_mask_q;
    assign out_base  = out_base_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ST_RUN);
    assign finish    = (state_q == ST_DONE);

endmodule
